num_register_bank: RTL
======================

NUM_REGISTER_BANK -- requirements
Module: num_register_bank

Interface
REQ-001 Parameter WIDTH, default 16: bit width of one stored number.
REQ-002 Parameter DEPTH, default 4: number of storage slots; legal range 2..16.
REQ-003 Port clk, input, 1: single system clock; all state updates occur on its rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port sw, input, WIDTH: number to be captured.
REQ-006 Port btn_store, input, 1: debounced store button level.
REQ-007 Port btn_view, input, 1: debounced view-advance button level.
REQ-008 Port btn_clear, input, 1: debounced clear button level.
REQ-009 Port disp_value, output, 2*WIDTH: {slot[view_ptr], slot[(view_ptr-1) mod DEPTH]}, registered.
REQ-010 Port view_ptr, output, clog2(DEPTH): index of the slot shown in the upper half.
REQ-011 Port count, output, clog2(DEPTH+1): number of valid slots, 0..DEPTH.
REQ-012 Port full, output, 1: high when count == DEPTH.
REQ-013 Port store_ack, output, 1: one-cycle pulse, the cycle after a slot write.

Function
REQ-014 Each button SHALL be registered every cycle; an event SHALL fire only in a cycle where level=1 and previous level=0, so a held button produces exactly one event.
REQ-015 A store event SHALL write sw into slot[wr_ptr], advance wr_ptr by one modulo DEPTH, and set view_ptr to the slot just written.
REQ-016 A store event SHALL increment count, saturating at DEPTH.
REQ-017 A store event while full SHALL overwrite the oldest slot (at wr_ptr), leave count at DEPTH, and keep full high.
REQ-018 A view event with count >= 1 SHALL step view_ptr to the next older valid slot; from the oldest valid slot it SHALL wrap to the newest.
REQ-019 A view event with count == 0 SHALL have no effect.
REQ-020 A clear event SHALL zero all slots, wr_ptr, view_ptr and count within one cycle.
REQ-021 Priority for events in the same cycle: clear > store > view; lower-priority events in that cycle SHALL be dropped.
REQ-022 Slots never written since reset or clear SHALL read as zero on disp_value.
REQ-023 disp_value, view_ptr, count and full SHALL reflect an event on the cycle after that event's clock edge.
REQ-024 sw SHALL be sampled only on the event clock edge; later sw changes SHALL NOT alter stored data.
REQ-025 Latency from a button rising edge to updated outputs SHALL be 2 cycles: 1 cycle for edge registration and 1 for the update.

Reset
REQ-026 On reset=1 at a clock edge, the block SHALL zero all slots, pointers and count, and SHALL drive full=0, store_ack=0 and disp_value=0.
REQ-027 Reset SHALL load the button history registers with the current button levels, so a button held through reset does not fire an event.
REQ-028 Reset asserted mid-operation SHALL override any event in the same cycle.

Structure
REQ-029 Package num_reg_pkg SHALL hold the WIDTH and DEPTH defaults and the derived pointer and count width functions.
REQ-030 A sub-module edge_pulse (a 1-bit registered rising-edge detector with synchronous reset) SHALL be instantiated once per button.
REQ-031 Slot storage SHALL be a register array; no RAM inference.

Verification
REQ-032 Reset, then btn_store with sw=16'h1234 -> after 2 cycles: disp_value[31:16]=16'h1234, disp_value[15:0]=0, count=1, store_ack pulsed once.
REQ-033 Store 16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD, then 16'hEEEE -> full=1, count=4, and slot 0 holds 16'hEEEE; the upper half of disp_value shows 16'hEEEE and the lower half shows 16'hDDDD.
REQ-034 With 3 valid slots, apply 3 view events -> view_ptr cycles through the next-older slots and returns to the newest.
REQ-035 Hold btn_store high for 50 cycles -> exactly one write and one store_ack.
REQ-036 Assert btn_store and btn_clear in the same cycle -> all outputs zero, count=0, no store_ack.
REQ-037 Assert reset while btn_view is held high, then deassert reset -> no view event fires and all outputs are zero.

Source files
------------

// File: rtl/num_reg_pkg.sv
// Shared defaults, width helpers and event priority for the number register bank.
package num_reg_pkg;

    localparam int WIDTH_DEFAULT = 16;
    localparam int DEPTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        EV_NONE,
        EV_CLEAR,
        EV_STORE,
        EV_VIEW
    } bank_event_e;

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Count must represent 0..depth inclusive, hence depth + 1 codes.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Clear beats store beats view; anything lower in the same cycle is dropped.
    function automatic bank_event_e resolve_event(input logic clear_ev,
                                                  input logic store_ev,
                                                  input logic view_ev);
        if (clear_ev) begin
            return EV_CLEAR;
        end
        if (store_ev) begin
            return EV_STORE;
        end
        if (view_ev) begin
            return EV_VIEW;
        end
        return EV_NONE;
    endfunction

endpackage

// File: rtl/edge_pulse.sv
// Registered rising-edge detector: one-cycle pulse the cycle after a 0->1 level change.
module edge_pulse (
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic pulse
);

    logic level_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            // Loading the live level means a button held through reset never fires.
            level_q <= level;
            pulse   <= 1'b0;
        end else begin
            level_q <= level;
            pulse   <= level & ~level_q;
        end
    end

endmodule

// File: rtl/num_register_bank.sv
// Stores switch values into a circular slot array and lets the user browse them
// newest-to-oldest; disp_value shows the viewed slot and the slot just below it.
module num_register_bank
    import num_reg_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [WIDTH-1:0]              sw,
    input  logic                          btn_store,
    input  logic                          btn_view,
    input  logic                          btn_clear,
    output logic [2*WIDTH-1:0]            disp_value,
    output logic [ptr_width(DEPTH)-1:0]   view_ptr,
    output logic [count_width(DEPTH)-1:0] count,
    output logic                          full,
    output logic                          store_ack
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam int CNT_W = count_width(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef logic [WIDTH-1:0] slot_t;

    logic             store_ev;
    logic             view_ev;
    logic             clear_ev;
    bank_event_e      ev;

    slot_t            slot_q [DEPTH];
    slot_t            slot_d [DEPTH];
    logic [PTR_W-1:0] wr_q;
    logic [PTR_W-1:0] wr_d;
    logic [PTR_W-1:0] view_q;
    logic [PTR_W-1:0] view_d;
    logic [PTR_W-1:0] oldest_ptr;
    logic [PTR_W-1:0] newest_ptr;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             store_ack_d;
    logic             store_ack_q;
    logic [2*WIDTH-1:0] disp_q;
    int               oldest_sum;

    // DEPTH need not be a power of two, so pointer wrap is explicit.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    function automatic logic [PTR_W-1:0] ptr_dec(input logic [PTR_W-1:0] p);
        return (p == '0) ? LAST_PTR : p - PTR_W'(1);
    endfunction

    edge_pulse u_store_edge (
        .clk   (clk),
        .reset (reset),
        .level (btn_store),
        .pulse (store_ev)
    );

    edge_pulse u_view_edge (
        .clk   (clk),
        .reset (reset),
        .level (btn_view),
        .pulse (view_ev)
    );

    edge_pulse u_clear_edge (
        .clk   (clk),
        .reset (reset),
        .level (btn_clear),
        .pulse (clear_ev)
    );

    assign ev = resolve_event(clear_ev, store_ev, view_ev);

    // Oldest valid slot sits count positions behind the write pointer.
    always_comb begin
        oldest_sum = int'(wr_q) + DEPTH - int'(count_q);
        oldest_ptr = (oldest_sum >= DEPTH) ? PTR_W'(oldest_sum - DEPTH)
                                           : PTR_W'(oldest_sum);
        newest_ptr = ptr_dec(wr_q);
    end

    // NOTE: every signal gets a hold-value default first, so no path leaves one unassigned (no latches).
    always_comb begin
        slot_d      = slot_q;
        wr_d        = wr_q;
        view_d      = view_q;
        count_d     = count_q;
        store_ack_d = 1'b0;

        case (ev)
            EV_CLEAR: begin
                for (int i = 0; i < DEPTH; i++) begin
                    slot_d[i] = '0;
                end
                wr_d    = '0;
                view_d  = '0;
                count_d = '0;
            end
            EV_STORE: begin
                // When full, wr_q already points at the oldest slot, so this overwrites it.
                slot_d[wr_q] = sw;
                wr_d         = ptr_inc(wr_q);
                view_d       = wr_q;
                if (count_q != FULL_CNT) begin
                    count_d = count_q + CNT_W'(1);
                end
                store_ack_d  = 1'b1;
            end
            EV_VIEW: begin
                if (count_q != '0) begin
                    view_d = (view_q == oldest_ptr) ? newest_ptr : ptr_dec(view_q);
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the slot array is reset explicitly; unwritten slots must read as zero, and it stays flops.
            for (int i = 0; i < DEPTH; i++) begin
                slot_q[i] <= '0;
            end
            wr_q        <= '0;
            view_q      <= '0;
            count_q     <= '0;
            store_ack_q <= 1'b0;
            disp_q      <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                slot_q[i] <= slot_d[i];
            end
            wr_q        <= wr_d;
            view_q      <= view_d;
            count_q     <= count_d;
            store_ack_q <= store_ack_d;
            // Built from next-state values so the display lands with the event, not a cycle later.
            disp_q      <= {slot_d[view_d], slot_d[ptr_dec(view_d)]};
        end
    end

    assign disp_value = disp_q;
    assign view_ptr   = view_q;
    assign count      = count_q;
    assign full       = (count_q == FULL_CNT);
    assign store_ack  = store_ack_q;

endmodule
